// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types for the initiator and the scratchpad responder.
// Holds the response encoding, the master FSM states and the error-counter helper.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_t;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } master_state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

    // Saturating bump of the non-OKAY response counter.
    function automatic logic [7:0] err_cnt_next(input logic [7:0] cnt, input logic [1:0] resp);
        if ((resp_t'(resp) != OKAY) && (cnt != ERR_CNT_MAX)) begin
            return cnt + 8'd1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite initiator: turns single-beat command/response requests into AXI4-Lite
// transactions, one outstanding at a time. All AXI outputs are registered or state-decoded.
module axi_lite_master
    import axi_lite_pkg::*;
#(
    parameter int DATA_BW_p = 32,
    parameter int ADDR_BW_p = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_cmd_valid,
    output logic                   o_cmd_ready,
    input  logic                   i_cmd_we,
    input  logic [ADDR_BW_p-1:0]   i_cmd_addr,
    input  logic [DATA_BW_p-1:0]   i_cmd_wdata,
    input  logic [DATA_BW_p/8-1:0] i_cmd_wstrb,
    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic                   o_rsp_we,
    output logic [DATA_BW_p-1:0]   o_rsp_rdata,
    output logic [1:0]             o_rsp_resp,
    output logic [7:0]             o_err_cnt,
    output logic [ADDR_BW_p-1:0]   o_axi_awaddr,
    output logic                   o_axi_awvalid,
    input  logic                   i_axi_awready,
    output logic [DATA_BW_p-1:0]   o_axi_wdata,
    output logic [DATA_BW_p/8-1:0] o_axi_wstrb,
    output logic                   o_axi_wvalid,
    input  logic                   i_axi_wready,
    input  logic [1:0]             i_axi_bresp,
    input  logic                   i_axi_bvalid,
    output logic                   o_axi_bready,
    output logic [ADDR_BW_p-1:0]   o_axi_araddr,
    output logic                   o_axi_arvalid,
    input  logic                   i_axi_arready,
    input  logic [DATA_BW_p-1:0]   i_axi_rdata,
    input  logic [1:0]             i_axi_rresp,
    input  logic                   i_axi_rvalid,
    output logic                   o_axi_rready
);

    master_state_t state;
    logic          aw_done;
    logic          w_done;
    logic          aw_hs;
    logic          w_hs;

    assign aw_hs = o_axi_awvalid & i_axi_awready;
    assign w_hs  = o_axi_wvalid  & i_axi_wready;

    assign o_cmd_ready  = (state == IDLE);
    assign o_axi_bready = (state == WR_RESP);
    assign o_axi_rready = (state == RD_RESP);
    assign o_rsp_valid  = (state == RSP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            o_axi_awaddr  <= '0;
            o_axi_awvalid <= 1'b0;
            o_axi_wdata   <= '0;
            o_axi_wstrb   <= '0;
            o_axi_wvalid  <= 1'b0;
            o_axi_araddr  <= '0;
            o_axi_arvalid <= 1'b0;
            o_rsp_we      <= 1'b0;
            o_rsp_rdata   <= '0;
            o_rsp_resp    <= '0;
            o_err_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        o_rsp_we <= i_cmd_we;
                        if (i_cmd_we) begin
                            o_axi_awaddr  <= i_cmd_addr;
                            o_axi_wdata   <= i_cmd_wdata;
                            o_axi_wstrb   <= i_cmd_wstrb;
                            o_axi_awvalid <= 1'b1;
                            o_axi_wvalid  <= 1'b1;
                            aw_done       <= 1'b0;
                            w_done        <= 1'b0;
                            state         <= WR_REQ;
                        end else begin
                            o_axi_araddr  <= i_cmd_addr;
                            o_axi_arvalid <= 1'b1;
                            state         <= RD_REQ;
                        end
                    end
                end

                WR_REQ: begin
                    if (aw_hs) begin
                        o_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        o_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    // Both channels may complete on the same edge, or in either order.
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (i_axi_bvalid) begin
                        o_rsp_resp  <= i_axi_bresp;
                        o_rsp_rdata <= '0;
                        o_err_cnt   <= err_cnt_next(o_err_cnt, i_axi_bresp);
                        state       <= RSP;
                    end
                end

                RD_REQ: begin
                    if (i_axi_arready) begin
                        o_axi_arvalid <= 1'b0;
                        state         <= RD_RESP;
                    end
                end

                RD_RESP: begin
                    if (i_axi_rvalid) begin
                        o_rsp_rdata <= i_axi_rdata;
                        o_rsp_resp  <= i_axi_rresp;
                        o_err_cnt   <= err_cnt_next(o_err_cnt, i_axi_rresp);
                        state       <= RSP;
                    end
                end

                RSP: begin
                    if (i_rsp_ready) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
